parent_nkid: RTL and testbench

//  Multi-kid successor of the single-kid sleep/cook parent FSM. Serves N_KID hungry requesters

---
 rtl/parent_nkid_pkg.sv | 12 +
 rtl/parent_nkid_if.sv | 21 ++
 rtl/parent_nkid_arbiter.sv | 29 ++
 rtl/parent_nkid.sv | 116 +++++++++++
 tb/tb_parent_nkid.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/parent_nkid_pkg.sv
// Shared definitions for the multi-kid parent controller.
//   state_t   : controller state encoding (SLEEP/COOK/SERVE; 2'd3 is illegal)
package parent_nkid_pkg;

  // Prefixed names keep these clear of the kid FSM definitions.
  typedef enum logic [1:0] {
    P_SLEEP = 2'd0,
    P_COOK  = 2'd1,
    P_SERVE = 2'd2
  } state_t;

endpackage

// File: rtl/parent_nkid_if.sv
// Request/serve bundle between the kids and the parent controller.
//   wakeup    : per-kid level request (kid side drives)
//   food      : one-hot meal pulse (parent drives)
//   busy      : parent is out of SLEEP
//   served_id : kid currently being cooked for / served
//   meals     : saturating count of completed serves
interface parent_nkid_if #(
  parameter int N_KID = 4,
  parameter int CNT_W = 8
);
  localparam int IDX_W = $clog2(N_KID);

  logic [N_KID-1:0] wakeup;
  logic [N_KID-1:0] food;
  logic             busy;
  logic [IDX_W-1:0] served_id;
  logic [CNT_W-1:0] meals;

  modport master (output wakeup, input food, input busy, input served_id, input meals);
  modport slave  (input wakeup, output food, output busy, output served_id, output meals);
endinterface

// File: rtl/parent_nkid_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per kid
//   last : index of the most recently granted kid
//   any  : at least one request present
//   idx  : first requesting kid searching last+1, last+2, ... (mod N_KID);
//          last itself is considered only after every other kid
module kid_rr_arbiter #(
  parameter int N_KID = 4,
  localparam int IDX_W = $clog2(N_KID)
) (
  input  logic [N_KID-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Walk the search order backwards so the nearest requester is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_KID; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_KID]) begin
        any = 1'b1;
        idx = IDX_W'((int'(last) + k) % N_KID);
      end
    end
  end

endmodule

// File: rtl/parent_nkid.sv
// Multi-kid sleep/cook/serve parent controller with round-robin fairness,
// a cooking delay and abort when the chosen kid stops asking.
//   clk    : rising-edge clock
//   resetb : asynchronous active-low reset
//   bus    : slave side of parent_nkid_if (wakeup in; food/busy/served_id/meals out)
//
// state  | meaning
// SLEEP  | idle, waiting for any wakeup
// COOK   | preparing a meal for served_id, cnt counts down to 0
// SERVE  | one-cycle food pulse to served_id
module parent_nkid
  import parent_nkid_pkg::*;
#(
  parameter int N_KID       = 4,
  parameter int COOK_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         resetb,
  parent_nkid_if.slave bus
);

  localparam int IDX_W = $clog2(N_KID);
  localparam int CW    = $clog2(COOK_CYCLES + 1);

  state_t           state_q, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [IDX_W-1:0] last_q, last_nx;
  logic [N_KID-1:0] food_q, food_nx;
  logic             busy_q;
  logic [IDX_W-1:0] served_q, served_nx;
  logic [CNT_W-1:0] meals_q, meals_nx;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  kid_rr_arbiter #(.N_KID(N_KID)) u_arb (
    .req  (bus.wakeup),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    last_nx   = last_q;
    food_nx   = '0;
    served_nx = served_q;
    meals_nx  = meals_q;
    case (state_q)
      P_SLEEP: begin
        if (pick_any) begin
          state_nx  = P_COOK;
          served_nx = pick_idx;
          cnt_nx    = CW'(COOK_CYCLES - 1);
        end
      end
      P_COOK: begin
        if (!bus.wakeup[served_q]) begin
          state_nx = P_SLEEP;
        end else if (cnt_q != '0) begin
          cnt_nx = cnt_q - CW'(1);
        end else begin
          state_nx          = P_SERVE;
          food_nx[served_q] = 1'b1;
          last_nx           = served_q;
          if (meals_q != {CNT_W{1'b1}}) meals_nx = meals_q + CNT_W'(1);
        end
      end
      P_SERVE: begin
        // last_q already holds the kid just served, so a lone requester can win again.
        if (pick_any) begin
          state_nx  = P_COOK;
          served_nx = pick_idx;
          cnt_nx    = CW'(COOK_CYCLES - 1);
        end else begin
          state_nx = P_SLEEP;
        end
      end
      default: state_nx = P_SLEEP;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= P_SLEEP;
      cnt_q   <= '0;
      last_q  <= IDX_W'(N_KID - 1);
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      last_q  <= last_nx;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      food_q   <= '0;
      busy_q   <= 1'b0;
      served_q <= '0;
      meals_q  <= '0;
    end else begin
      food_q   <= food_nx;
      busy_q   <= (state_nx != P_SLEEP);
      served_q <= served_nx;
      meals_q  <= meals_nx;
    end
  end

  assign bus.food      = food_q;
  assign bus.busy      = busy_q;
  assign bus.served_id = served_q;
  assign bus.meals     = meals_q;

endmodule

// File: tb/tb_parent_nkid.sv
module tb_parent_nkid;

  localparam int N_KID = 4;
  localparam int COOK  = 3;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] wakeup = 4'b0000;

  int errors = 0;
  int checks = 0;

  parent_nkid_if #(.N_KID(N_KID), .CNT_W(8)) bus_a ();
  parent_nkid_if #(.N_KID(N_KID), .CNT_W(2)) bus_b ();

  assign bus_a.wakeup = wakeup;
  assign bus_b.wakeup = wakeup;

  parent_nkid #(.N_KID(N_KID), .COOK_CYCLES(COOK), .CNT_W(8)) dut (
    .clk(clk), .resetb(resetb), .bus(bus_a));
  parent_nkid #(.N_KID(N_KID), .COOK_CYCLES(COOK), .CNT_W(2)) dut_sat (
    .clk(clk), .resetb(resetb), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference: mode 0=asleep, 1=cooking, 2=serving; rem = cook cycles still to spend.
  int         m_mode, m_rem, m_kid, m_last, m_meals, m_meals_sat;
  logic [3:0] m_food;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] w, input int last);
    for (int k = 1; k <= N_KID; k++)
      if (w[(last + k) % N_KID]) return (last + k) % N_KID;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_kid = 0; m_last = N_KID - 1;
    m_meals = 0; m_meals_sat = 0; m_food = 4'b0000;
  endtask

  task automatic model_edge(input logic [3:0] w);
    int p;
    m_food = 4'b0000;
    case (m_mode)
      0, 2: begin
        p = pick(w, m_last);
        if (p >= 0) begin m_mode = 1; m_kid = p; m_rem = COOK; end
        else m_mode = 0;
      end
      default: begin
        if (!w[m_kid]) m_mode = 0;
        else if (m_rem > 1) m_rem--;
        else begin
          m_mode = 2;
          m_food = 4'(1 << m_kid);
          m_last = m_kid;
          m_meals = (m_meals < 255) ? m_meals + 1 : 255;
          m_meals_sat = (m_meals_sat < 3) ? m_meals_sat + 1 : 3;
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".food"},  32'(bus_a.food), 32'(m_food));
    check({tag, ".busy"},  32'(bus_a.busy), 32'(m_mode != 0));
    check({tag, ".id"},    32'(bus_a.served_id), 32'(m_kid));
    check({tag, ".meals"}, 32'(bus_a.meals), 32'(m_meals));
    check({tag, ".sat"},   32'(bus_b.meals), 32'(m_meals_sat));
    check({tag, ".food2"}, 32'(bus_b.food), 32'(m_food));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(wakeup);
    #1;
    check_all(tag);
  endtask

  // Called just after an edge; reset pulse lands mid-cycle.
  task automatic do_reset(input string tag);
    #1 resetb = 1'b0;
    #1 model_reset();
    check_all(tag);
    #1 resetb = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset held with every kid hungry.
    wakeup = 4'b1111;
    repeat (3) @(posedge clk);
    #1 check_all("rst_hold");
    #2 resetb = 1'b1;
    step("rst_cook");
    do_reset("rst_midcook");
    check("rst_mid_busy", 32'(bus_a.busy), 32'd0);

    // Single kid: pulse every COOK+1 cycles.
    wakeup = 4'b0100;
    repeat (13) step("single");
    check("single_meals", 32'(bus_a.meals), 32'd3);

    // Fairness with everyone hungry.
    do_reset("rst_fair");
    wakeup = 4'b1111;
    repeat (22) step("fair");

    // Abort: kid 1 drops during cooking while kid 3 waits.
    do_reset("rst_abort");
    wakeup = 4'b0010;
    step("abort_c1");
    wakeup = 4'b1000;
    step("abort_c2");
    check("abort_busy", 32'(bus_a.busy), 32'd0);
    repeat (6) step("abort_k3");

    // Drop during SERVE.
    do_reset("rst_drop");
    wakeup = 4'b0001;
    for (int i = 0; i < 10 && m_mode != 2; i++) step("drop_wait");
    check("drop_reached_serve", 32'(m_mode), 32'd2);
    wakeup = 4'b0000;
    step("drop_after");
    check("drop_busy", 32'(bus_a.busy), 32'd0);
    step("drop_idle");

    // Randomized traffic; dut_sat saturates at 3.
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) wakeup = 4'($urandom);
      if (i % 150 == 149) do_reset("rst_rand_mid");
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
